// File: rtl/key_event_ctrl_if.sv
// ---------------------------------------------------------------------------
// key_event_ctrl_if
// Event port between the key event scheduler (master) and the UI/menu
// logic that consumes key events (slave).
//
// Signals
//   o_evt_valid  master->slave  event register holds a valid event
//   o_evt_key    master->slave  key index of the event (KEY_W bits)
//   o_evt_type   master->slave  00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
//   I_evt_ready  slave->master  consumer takes the event while valid is high
// ---------------------------------------------------------------------------
interface key_event_ctrl_if #(
   parameter int KEY_W = 2
);
   logic             o_evt_valid;
   logic [KEY_W-1:0] o_evt_key;
   logic [1:0]       o_evt_type;
   logic             I_evt_ready;

   modport master (
      output o_evt_valid,
      output o_evt_key,
      output o_evt_type,
      input  I_evt_ready
   );

   modport slave (
      input  o_evt_valid,
      input  o_evt_key,
      input  o_evt_type,
      output I_evt_ready
   );
endinterface

// File: rtl/key_event_ctrl.sv
// ---------------------------------------------------------------------------
// key_event_ctrl
// Event scheduler for N_KEYS debounced key levels. Each key has a small FSM
// that produces PRESS, RELEASE, LONG (and optionally REPEAT) events into a
// one-deep pending slot; a round-robin arbiter moves pending events into a
// single output register presented on a valid/ready event port.
//
// Build option
//   KEY_REPEAT_EN  defined: a key held past LONG emits REPEAT every
//                  REPEAT_CNT cycles. Undefined: no REPEAT logic, LONG holds
//                  until release, REPEAT_CNT is not used.
//
// Ports
//   I_clk      system clock
//   I_rst_n    asynchronous active-low reset
//   I_key      debounced key levels (N_KEYS), synchronous to I_clk
//   evt_if     event port (master): o_evt_valid/o_evt_key/o_evt_type out,
//              I_evt_ready in
//   o_pressed  registered per-key pressed state, active-high
//   o_drop     one-cycle pulse when an event is lost because the key's
//              pending slot was still occupied
// ---------------------------------------------------------------------------
module key_event_ctrl #(
   parameter int N_KEYS      = 4,
   parameter int KEY_W       = 2,
   parameter bit KEY_ACT_LOW = 1'b1,
   parameter int LONG_CNT    = 50_000_000,
   parameter int REPEAT_CNT  = 10_000_000,
   parameter int CNT_W       = 26
) (
   input  logic                    I_clk,
   input  logic                    I_rst_n,
   input  logic [N_KEYS-1:0]       I_key,
   key_event_ctrl_if.master        evt_if,
   output logic [N_KEYS-1:0]       o_pressed,
   output logic                    o_drop
);

   localparam logic [1:0] EVT_PRESS   = 2'b00;
   localparam logic [1:0] EVT_RELEASE = 2'b01;
   localparam logic [1:0] EVT_LONG    = 2'b10;

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
`ifdef KEY_REPEAT_EN
   localparam logic [1:0]       EVT_REPEAT  = 2'b11;
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
`else
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_HELD = 2'b01,
      ST_LONG = 2'b10
   } key_state_e;

   // ---------------- input sampling ----------------
   logic              arm_q;
   logic [N_KEYS-1:0] key_prev_q;
   logic [N_KEYS-1:0] pressed_q;
   logic [N_KEYS-1:0] pressed_s;
   logic [N_KEYS-1:0] prev_pressed_s;
   logic [N_KEYS-1:0] press_edge_s;
   logic [N_KEYS-1:0] rel_edge_s;

   // ---------------- per-key FSM ----------------
   key_state_e        state_q [N_KEYS];
   key_state_e        state_d [N_KEYS];
   logic [CNT_W-1:0]  cnt_q   [N_KEYS];
   logic [CNT_W-1:0]  cnt_d   [N_KEYS];
   logic [N_KEYS-1:0] evt_v_s;
   logic [1:0]        evt_t_s [N_KEYS];

   // ---------------- pending slots ----------------
   logic [N_KEYS-1:0] slot_v_q;
   logic [N_KEYS-1:0] slot_v_d;
   logic [1:0]        slot_t_q [N_KEYS];
   logic [1:0]        slot_t_d [N_KEYS];
   logic [N_KEYS-1:0] drop_s;
   logic              drop_q;

   // ---------------- arbiter / output register ----------------
   logic              load_s;
   logic              gnt_found_s;
   logic [N_KEYS-1:0] gnt_s;
   logic [KEY_W-1:0]  gnt_idx_s;
   logic [1:0]        gnt_type_s;
   logic [KEY_W-1:0]  gnt_ptr_s;
   logic [KEY_W-1:0]  ptr_q;
   logic [KEY_W-1:0]  ptr_d;
   logic              out_v_q;
   logic              out_v_d;
   logic [KEY_W-1:0]  out_k_q;
   logic [KEY_W-1:0]  out_k_d;
   logic [1:0]        out_t_q;
   logic [1:0]        out_t_d;

   // Edge detection on the pressed level; nothing fires until the arm cycle
   // has captured the levels present when reset was released.
   always_comb begin
      pressed_s      = I_key ^ {N_KEYS{KEY_ACT_LOW}};
      prev_pressed_s = key_prev_q ^ {N_KEYS{KEY_ACT_LOW}};
      press_edge_s   = pressed_s & ~prev_pressed_s & {N_KEYS{arm_q}};
      rel_edge_s     = ~pressed_s & prev_pressed_s & {N_KEYS{arm_q}};
   end

   // Input history, arm flag and registered pressed state.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         arm_q      <= 1'b0;
         key_prev_q <= {N_KEYS{1'b0}};
         pressed_q  <= {N_KEYS{1'b0}};
      end else begin
         arm_q      <= 1'b1;
         key_prev_q <= I_key;
         pressed_q  <= pressed_s;
      end
   end

   // Per-key next state, hold counter and event generation.
   always_comb begin
      for (int i = 0; i < N_KEYS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         evt_v_s[i] = 1'b0;
         evt_t_s[i] = EVT_PRESS;
         if (rel_edge_s[i]) begin
            // Release wins over any timer event this cycle. A key that was
            // already down across reset sits in IDLE and releases silently.
            state_d[i] = ST_IDLE;
            cnt_d[i]   = CNT_ZERO;
            if (state_q[i] != ST_IDLE) begin
               evt_v_s[i] = 1'b1;
               evt_t_s[i] = EVT_RELEASE;
            end else begin
               evt_v_s[i] = 1'b0;
            end
         end else begin
            case (state_q[i])
               ST_IDLE: begin
                  if (press_edge_s[i]) begin
                     state_d[i] = ST_HELD;
                     cnt_d[i]   = CNT_ZERO;
                     evt_v_s[i] = 1'b1;
                     evt_t_s[i] = EVT_PRESS;
                  end else begin
                     cnt_d[i]   = CNT_ZERO;
                  end
               end
               ST_HELD: begin
                  if (cnt_q[i] == LONG_LAST) begin
                     state_d[i] = ST_LONG;
                     cnt_d[i]   = CNT_ZERO;
                     evt_v_s[i] = 1'b1;
                     evt_t_s[i] = EVT_LONG;
                  end else begin
                     cnt_d[i]   = cnt_q[i] + CNT_ONE;
                  end
               end
               ST_LONG: begin
`ifdef KEY_REPEAT_EN
                  if (cnt_q[i] == REPEAT_LAST) begin
                     cnt_d[i]   = CNT_ZERO;
                     evt_v_s[i] = 1'b1;
                     evt_t_s[i] = EVT_REPEAT;
                  end else begin
                     cnt_d[i]   = cnt_q[i] + CNT_ONE;
                  end
`else
                  // Counter saturates; LONG state just waits for release.
                  if (cnt_q[i] != CNT_MAX) begin
                     cnt_d[i] = cnt_q[i] + CNT_ONE;
                  end else begin
                     cnt_d[i] = cnt_q[i];
                  end
`endif
               end
               default: begin
                  state_d[i] = ST_IDLE;
                  cnt_d[i]   = CNT_ZERO;
               end
            endcase
         end
      end
   end

   // Per-key FSM state and hold counter registers.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         for (int i = 0; i < N_KEYS; i++) begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= CNT_ZERO;
         end
      end else begin
         for (int i = 0; i < N_KEYS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // Round-robin search starting at ptr_q; only grants when the output
   // register can take a new event this cycle.
   always_comb begin
      load_s      = ~out_v_q | evt_if.I_evt_ready;
      gnt_found_s = 1'b0;
      gnt_s       = {N_KEYS{1'b0}};
      gnt_idx_s   = {KEY_W{1'b0}};
      gnt_type_s  = EVT_PRESS;
      gnt_ptr_s   = ptr_q;
      for (int off = 0; off < N_KEYS; off++) begin
         int idx;
         idx = (int'(ptr_q) + off) % N_KEYS;
         if (load_s && !gnt_found_s && slot_v_q[idx]) begin
            gnt_found_s = 1'b1;
            gnt_s[idx]  = 1'b1;
            gnt_idx_s   = KEY_W'(idx);
            gnt_type_s  = slot_t_q[idx];
            gnt_ptr_s   = KEY_W'((idx + 1) % N_KEYS);
         end else begin
            gnt_found_s = gnt_found_s;
         end
      end
   end

   // Pending slot update: a slot granted this cycle may reload at once;
   // an occupied, ungranted slot keeps its event and the new one is lost.
   always_comb begin
      for (int i = 0; i < N_KEYS; i++) begin
         slot_v_d[i] = slot_v_q[i];
         slot_t_d[i] = slot_t_q[i];
         drop_s[i]   = 1'b0;
         if (evt_v_s[i]) begin
            if (slot_v_q[i] && !gnt_s[i]) begin
               drop_s[i] = 1'b1;
            end else begin
               slot_v_d[i] = 1'b1;
               slot_t_d[i] = evt_t_s[i];
            end
         end else if (gnt_s[i]) begin
            slot_v_d[i] = 1'b0;
         end else begin
            slot_v_d[i] = slot_v_q[i];
         end
      end
   end

   // Pending slot registers and drop pulse.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         slot_v_q <= {N_KEYS{1'b0}};
         for (int i = 0; i < N_KEYS; i++) begin
            slot_t_q[i] <= EVT_PRESS;
         end
         drop_q   <= 1'b0;
      end else begin
         slot_v_q <= slot_v_d;
         for (int i = 0; i < N_KEYS; i++) begin
            slot_t_q[i] <= slot_t_d[i];
         end
         drop_q   <= |drop_s;
      end
   end

   // Output register next state; key/type only change on a load, so a
   // stalled event is never retracted or altered.
   always_comb begin
      out_v_d = out_v_q;
      out_k_d = out_k_q;
      out_t_d = out_t_q;
      ptr_d   = ptr_q;
      if (load_s) begin
         if (gnt_found_s) begin
            out_v_d = 1'b1;
            out_k_d = gnt_idx_s;
            out_t_d = gnt_type_s;
            ptr_d   = gnt_ptr_s;
         end else begin
            out_v_d = 1'b0;
         end
      end else begin
         out_v_d = out_v_q;
      end
   end

   // Output event register and round-robin pointer.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         out_v_q <= 1'b0;
         out_k_q <= {KEY_W{1'b0}};
         out_t_q <= EVT_PRESS;
         ptr_q   <= {KEY_W{1'b0}};
      end else begin
         out_v_q <= out_v_d;
         out_k_q <= out_k_d;
         out_t_q <= out_t_d;
         ptr_q   <= ptr_d;
      end
   end

   assign evt_if.o_evt_valid = out_v_q;
   assign evt_if.o_evt_key   = out_k_q;
   assign evt_if.o_evt_type  = out_t_q;
   assign o_pressed          = pressed_q;
   assign o_drop             = drop_q;

endmodule
